// File: rtl/ucsbece154a_rf_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
package ucsbece154a_rf_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned NREGS_DEF  = 32;
  localparam int unsigned NRD_DEF    = 2;

  // x0 is hardwired to zero; it can never be written or reserved.
  localparam int unsigned ZERO_REG = 0;

  // Ceiling log2, for toolchains without a usable $clog2 in constant context.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ucsbece154a_rf_scoreboard.sv
// Pending-bit scoreboard: reserve/release per register plus a running pending count.
module ucsbece154a_rf_scoreboard
  import ucsbece154a_rf_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_DEF,
  localparam int unsigned AW = clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n_i,
  input  logic             we_i,
  input  logic [AW-1:0]    wa_i,
  input  logic             rsv_i,
  input  logic [AW-1:0]    rsva_i,
  output logic [NREGS-1:0] pend_o,
  output logic [AW:0]      npend_o
);

  localparam logic [AW-1:0] ZeroAddr = AW'(ZERO_REG);

  logic [NREGS-1:0] pend_q, pend_d;
  logic [AW:0]      npend_q, npend_d;
  logic             wr_valid, rsv_valid;
  logic             set_new, rel_old;

  // Next pending vector and count; a reserve overrides a release to the same register.
  always_comb begin
    wr_valid  = we_i && (wa_i != ZeroAddr);
    rsv_valid = rsv_i && (rsva_i != ZeroAddr);

    set_new = rsv_valid && !pend_q[rsva_i];
    rel_old = wr_valid && pend_q[wa_i] && !(rsv_valid && (rsva_i == wa_i));

    pend_d = pend_q;
    if (wr_valid) begin
      pend_d[wa_i] = 1'b0;
    end
    if (rsv_valid) begin
      pend_d[rsva_i] = 1'b1;
    end

    npend_d = npend_q;
    case ({set_new, rel_old})
      2'b10:   npend_d = npend_q + (AW+1)'(1);
      2'b01:   npend_d = npend_q - (AW+1)'(1);
      default: npend_d = npend_q;
    endcase
  end

  // Scoreboard state, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pend_q  <= '0;
      npend_q <= '0;
    end else begin
      pend_q  <= pend_d;
      npend_q <= npend_d;
    end
  end

  assign pend_o  = pend_q;
  assign npend_o = npend_q;

endmodule

// File: rtl/ucsbece154a_rf_sb.sv
// Multi-read-port register file with scoreboard and optional write-through bypass.
module ucsbece154a_rf_sb
  import ucsbece154a_rf_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned NREGS  = NREGS_DEF,
  parameter int unsigned NRD    = NRD_DEF,
  parameter bit          BYPASS = 1'b1,
  localparam int unsigned AW = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n_i,
  input  logic [NRD*AW-1:0]     ra_i,
  output logic [NRD*DATA_W-1:0] rd_o,
  output logic [NRD-1:0]        rdy_o,
  input  logic                  we_i,
  input  logic [AW-1:0]         wa_i,
  input  logic [DATA_W-1:0]     wd_i,
  input  logic                  rsv_i,
  input  logic [AW-1:0]         rsva_i,
  output logic [AW:0]           npend_o
);

  localparam logic [AW-1:0] ZeroAddr = AW'(ZERO_REG);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [NREGS-1:0]  pend;

  // Data array; x0 is never written so it stays at its reset value.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (wa_i != ZeroAddr)) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  ucsbece154a_rf_scoreboard #(
    .NREGS (NREGS)
  ) u_scoreboard (
    .clk     (clk),
    .rst_n_i (rst_n_i),
    .we_i    (we_i),
    .wa_i    (wa_i),
    .rsv_i   (rsv_i),
    .rsva_i  (rsva_i),
    .pend_o  (pend),
    .npend_o (npend_o)
  );

  // Per-port read mux: zero register, then same-cycle write forwarding, then stored value.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] ra_k;
    logic          hit;

    assign ra_k = ra_i[k*AW +: AW];
    assign hit  = BYPASS && we_i && (wa_i == ra_k) && (ra_k != ZeroAddr);

    assign rd_o[k*DATA_W +: DATA_W] = (ra_k == ZeroAddr) ? '0 :
                                      hit                ? wd_i :
                                                           regs_q[ra_k];
    // A register being released this cycle counts as ready only when its data is forwarded.
    assign rdy_o[k] = (ra_k == ZeroAddr) || !pend[ra_k] || hit;
  end

endmodule

// File: tb/tb_ucsbece154a_rf_sb.sv
// Randomised and directed bench for ucsbece154a_rf_sb, bypass and non-bypass builds.
module tb_ucsbece154a_rf_sb;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int NP = 2;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NP*AW-1:0] ra = '0;
  logic          we = 1'b0;
  logic [AW-1:0] wa = '0;
  logic [DW-1:0] wd = '0;
  logic          rsv = 1'b0;
  logic [AW-1:0] rsva = '0;

  logic [NP*DW-1:0] rd_b, rd_n;
  logic [NP-1:0]    rdy_b, rdy_n;
  logic [AW:0]      np_b, np_n;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: plain register contents and pending flags.
  logic [DW-1:0] mreg [NR];
  bit            mpend [NR];

  always #5 clk = ~clk;

  ucsbece154a_rf_sb #(
    .DATA_W (DW),
    .NREGS  (NR),
    .NRD    (NP),
    .BYPASS (1'b1)
  ) dut_byp (
    .clk     (clk),
    .rst_n_i (rst_n),
    .ra_i    (ra),
    .rd_o    (rd_b),
    .rdy_o   (rdy_b),
    .we_i    (we),
    .wa_i    (wa),
    .wd_i    (wd),
    .rsv_i   (rsv),
    .rsva_i  (rsva),
    .npend_o (np_b)
  );

  ucsbece154a_rf_sb #(
    .DATA_W (DW),
    .NREGS  (NR),
    .NRD    (NP),
    .BYPASS (1'b0)
  ) dut_nob (
    .clk     (clk),
    .rst_n_i (rst_n),
    .ra_i    (ra),
    .rd_o    (rd_n),
    .rdy_o   (rdy_n),
    .we_i    (we),
    .wa_i    (wa),
    .wd_i    (wd),
    .rsv_i   (rsv),
    .rsva_i  (rsva),
    .npend_o (np_n)
  );

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input bit byp, input int a);
    if (a == 0) return '0;
    if (byp && we && (int'(wa) == a)) return wd;
    return mreg[a];
  endfunction

  function automatic logic exp_rdy(input bit byp, input int a);
    if (a == 0) return 1'b1;
    if (byp && we && (int'(wa) == a)) return 1'b1;
    return !mpend[a];
  endfunction

  function automatic int pend_count();
    int c = 0;
    for (int i = 0; i < NR; i++) c += int'(mpend[i]);
    return c;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NR; i++) begin
      mreg[i]  = '0;
      mpend[i] = 1'b0;
    end
  endtask

  // Advance one clock: the reference applies the inputs present at the edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      if (we && wa != 0) begin
        mreg[wa]  = wd;
        mpend[wa] = 1'b0;
      end
      if (rsv && rsva != 0) mpend[rsva] = 1'b1;
    end
    #1;
  endtask

  task automatic check_all(input string tag);
    int a;
    #1;
    for (int k = 0; k < NP; k++) begin
      a = int'(ra[k*AW +: AW]);
      chk($sformatf("%s rd%0d byp", tag, k), rd_b[k*DW +: DW], exp_rd(1'b1, a));
      chk($sformatf("%s rd%0d nob", tag, k), rd_n[k*DW +: DW], exp_rd(1'b0, a));
      chk($sformatf("%s rdy%0d byp", tag, k), DW'(rdy_b[k]), DW'(exp_rdy(1'b1, a)));
      chk($sformatf("%s rdy%0d nob", tag, k), DW'(rdy_n[k]), DW'(exp_rdy(1'b0, a)));
    end
    chk({tag, " npend byp"}, DW'(np_b), DW'(pend_count()));
    chk({tag, " npend nob"}, DW'(np_n), DW'(pend_count()));
  endtask

  task automatic idle();
    we = 1'b0;
    rsv = 1'b0;
  endtask

  initial begin
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    ra = {5'd3, 5'd1};
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Write then read back; write to x0 discarded.
    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; ra = '0;
    tick();
    idle(); ra = {5'd0, 5'd5};
    check_all("wr_rd");
    chk("wr_rd x5", rd_b[31:0], 32'hDEADBEEF);
    we = 1'b1; wa = 5'd0; wd = 32'h1234;
    tick();
    idle(); ra = {5'd0, 5'd0};
    check_all("wr_x0");
    chk("wr_x0 rd", rd_n[31:0], 32'h0);

    // Same-cycle forwarding on port 1.
    we = 1'b1; wa = 5'd7; wd = 32'hA5A5A5A5; ra = {5'd7, 5'd5};
    check_all("bypass");
    chk("bypass byp", rd_b[63:32], 32'hA5A5A5A5);
    chk("bypass nob old", rd_n[63:32], 32'h0);
    tick();
    idle();
    check_all("bypass_next");
    chk("bypass nob new", rd_n[63:32], 32'hA5A5A5A5);

    // Reserve and release x3.
    rsv = 1'b1; rsva = 5'd3;
    tick();
    idle(); ra = {5'd0, 5'd3};
    check_all("rsv3");
    chk("rsv3 rdy", DW'(rdy_b[0]), 32'd0);
    chk("rsv3 npend", DW'(np_b), 32'd1);
    we = 1'b1; wa = 5'd3; wd = 32'h33;
    check_all("rel3_same");
    chk("rel3 rdy byp", DW'(rdy_b[0]), 32'd1);
    chk("rel3 rdy nob", DW'(rdy_n[0]), 32'd0);
    tick();
    idle();
    check_all("rel3_next");
    chk("rel3 npend", DW'(np_n), 32'd0);

    // Reserve beats release on the same register; cross-register swap keeps count.
    rsv = 1'b1; rsva = 5'd4;
    tick();
    rsv = 1'b1; rsva = 5'd4; we = 1'b1; wa = 5'd4; wd = 32'h55;
    tick();
    idle(); ra = {5'd6, 5'd4};
    check_all("collide");
    chk("collide data", rd_b[31:0], 32'h55);
    chk("collide rdy", DW'(rdy_b[0]), 32'd0);
    chk("collide npend", DW'(np_b), 32'd1);
    rsv = 1'b1; rsva = 5'd6; we = 1'b1; wa = 5'd4; wd = 32'h66;
    tick();
    idle();
    check_all("swap");
    chk("swap npend", DW'(np_n), 32'd1);

    // Fill the scoreboard, saturate on re-reserve, drain, and try to underflow.
    for (int i = 1; i < NR; i++) begin
      rsv = 1'b1; rsva = AW'(i);
      tick();
    end
    idle();
    check_all("fill");
    chk("fill npend", DW'(np_b), 32'd31);
    rsv = 1'b1; rsva = 5'd10;
    tick();
    idle();
    check_all("rersv");
    chk("rersv npend", DW'(np_b), 32'd31);
    for (int i = 1; i < NR; i++) begin
      we = 1'b1; wa = AW'(i); wd = $urandom;
      tick();
    end
    we = 1'b1; wa = 5'd5; wd = 32'h77;
    tick();
    idle();
    check_all("drain");
    chk("drain npend", DW'(np_n), 32'd0);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      we   = ($urandom_range(0, 1) == 1);
      wa   = AW'($urandom_range(0, NR - 1));
      wd   = $urandom;
      rsv  = ($urandom_range(0, 9) < 4);
      rsva = AW'($urandom_range(0, NR - 1));
      for (int k = 0; k < NP; k++) begin
        ra[k*AW +: AW] = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, NR - 1));
      end
      check_all("rand");
      tick();
    end

    // Asynchronous reset between edges, mid-operation.
    idle(); ra = {5'd9, 5'd5};
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rd byp", rd_b[31:0] | rd_b[63:32], 32'h0);
    chk("async rd nob", rd_n[31:0] | rd_n[63:32], 32'h0);
    chk("async rdy", DW'({rdy_b, rdy_n}), 32'hF);
    chk("async npend", DW'(np_b) | DW'(np_n), 32'h0);
    model_clear();
    check_all("async");
    @(negedge clk);
    rst_n = 1'b1;
    we = 1'b1; wa = 5'd9; wd = 32'hCAFEF00D; rsv = 1'b1; rsva = 5'd2;
    tick();
    idle(); ra = {5'd2, 5'd9};
    check_all("post_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
